// File: rtl/lsu_mem_port_pkg.sv
// Shared LSU definitions: MemRW access codes, store-width func3 codes, FSM states
// and small decode helpers used by the control decoder and the memory port.
package lsu_mem_port_pkg;

   localparam logic [2:0] MEMRW_LB  = 3'b000;
   localparam logic [2:0] MEMRW_LH  = 3'b001;
   localparam logic [2:0] MEMRW_LW  = 3'b010;
   localparam logic [2:0] MEMRW_LHU = 3'b101;
   localparam logic [2:0] MEMRW_LBU = 3'b110;
   localparam logic [2:0] MEMRW_ST  = 3'b111;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ACC1 = 2'b01,
      ST_ACC2 = 2'b10,
      ST_RESP = 2'b11
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } lsu_size_e;

   function automatic lsu_size_e access_size(input logic [2:0] memrw, input logic [2:0] func3);
      lsu_size_e sz;
      case (memrw)
         MEMRW_LB, MEMRW_LBU: sz = SZ_BYTE;
         MEMRW_LH, MEMRW_LHU: sz = SZ_HALF;
         MEMRW_ST: begin
            case (func3)
               F3_SB:   sz = SZ_BYTE;
               F3_SH:   sz = SZ_HALF;
               default: sz = SZ_WORD;
            endcase
         end
         default: sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   function automatic logic access_illegal(input logic [2:0] memrw, input logic [2:0] func3);
      logic ill;
      case (memrw)
         3'b011, 3'b100: ill = 1'b1;
         MEMRW_ST:       ill = (func3 > F3_SW);
         default:        ill = 1'b0;
      endcase
      return ill;
   endfunction

   function automatic logic access_signed(input logic [2:0] memrw);
      return (memrw == MEMRW_LB) || (memrw == MEMRW_LH);
   endfunction

   // An access is misaligned when its bytes straddle a 4-byte word boundary.
   function automatic logic access_misaligned(input lsu_size_e sz, input logic [1:0] off);
      return ((sz == SZ_HALF) && (off == 2'b11)) || ((sz == SZ_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_mem_port_lane_fmt.sv
// Byte-lane formatter: store lane enables/data for both beats, and load
// extraction with sign or zero extension from up to two SRAM words.
module lsu_lane_fmt
   import lsu_mem_port_pkg::*;
(
   input  lsu_size_e   size_i,
   input  logic [1:0]  offset_i,
   input  logic        sign_i,
   input  logic [31:0] st_data_i,
   input  logic [31:0] ld_first_i,
   input  logic [31:0] ld_second_i,
   output logic [3:0]  st_be_lo_o,
   output logic [3:0]  st_be_hi_o,
   output logic [31:0] st_data_lo_o,
   output logic [31:0] st_data_hi_o,
   output logic [31:0] ld_data_o
);

   logic [7:0]  mask_s;
   logic [7:0]  be_pair_s;
   logic [63:0] st_pair_s;
   logic [31:0] ld_raw_s;
   logic [4:0]  shamt_s;

   // Shift lane mask and data across a two-word window starting at the byte offset.
   always_comb begin
      shamt_s = {offset_i, 3'b000};
      case (size_i)
         SZ_BYTE: mask_s = 8'h01;
         SZ_HALF: mask_s = 8'h03;
         SZ_WORD: mask_s = 8'h0F;
         default: mask_s = 8'h00;
      endcase
      be_pair_s    = mask_s << offset_i;
      st_pair_s    = {32'h0000_0000, st_data_i} << shamt_s;
      st_be_lo_o   = be_pair_s[3:0];
      st_be_hi_o   = be_pair_s[7:4];
      st_data_lo_o = st_pair_s[31:0];
      st_data_hi_o = st_pair_s[63:32];
      ld_raw_s     = 32'({ld_second_i, ld_first_i} >> shamt_s);
      case (size_i)
         SZ_BYTE: ld_data_o = {{24{sign_i & ld_raw_s[7]}}, ld_raw_s[7:0]};
         SZ_HALF: ld_data_o = {{16{sign_i & ld_raw_s[15]}}, ld_raw_s[15:0]};
         SZ_WORD: ld_data_o = ld_raw_s;
         default: ld_data_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit port to a single-cycle-latency word SRAM; splits accesses that
// cross a word boundary into two beats and returns one extended load result.
module lsu_mem_port
   import lsu_mem_port_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int SRAM_AW = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [2:0]         MemRW,
   input  logic [2:0]         func3,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [31:0]        wdata,
   output logic               resp_valid,
   output logic [31:0]        rdata,
   output logic               resp_err,
   output logic               stall,
   output logic               sram_en,
   output logic               sram_we,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [3:0]         sram_be,
   output logic [31:0]        sram_wdata,
   input  logic [31:0]        sram_rdata
);

   localparam logic [SRAM_AW-1:0] WORD_STEP = {{(SRAM_AW-1){1'b0}}, 1'b1};

   lsu_state_e         state_q, state_d;
   logic [2:0]         memrw_q;
   logic [2:0]         func3_q;
   logic [SRAM_AW+1:0] addr_q;
   logic [31:0]        wdata_q;
   logic [31:0]        hold_q;

   lsu_size_e          size_s;
   logic               illegal_s;
   logic               signed_s;
   logic               misaligned_s;
   logic               store_s;
   logic               accept_s;
   logic [SRAM_AW-1:0] word_addr_s;
   logic [31:0]        ld_first_s;
   logic [3:0]         be_lo_s, be_hi_s;
   logic [31:0]        data_lo_s, data_hi_s, ld_data_s;
   logic               unused_addr_s;

   assign unused_addr_s = ^addr[ADDR_W-1:SRAM_AW+2];

   assign size_s       = access_size(memrw_q, func3_q);
   assign illegal_s    = access_illegal(memrw_q, func3_q);
   assign signed_s     = access_signed(memrw_q);
   assign misaligned_s = access_misaligned(size_s, addr_q[1:0]);
   assign store_s      = (memrw_q == MEMRW_ST);
   assign word_addr_s  = addr_q[SRAM_AW+1:2];
   assign req_ready    = (state_q == ST_IDLE);
   assign stall        = ~req_ready;
   assign accept_s     = req_valid & req_ready;
   assign ld_first_s   = misaligned_s ? hold_q : sram_rdata;

   lsu_lane_fmt u_lane_fmt (
      .size_i       (size_s),
      .offset_i     (addr_q[1:0]),
      .sign_i       (signed_s),
      .st_data_i    (wdata_q),
      .ld_first_i   (ld_first_s),
      .ld_second_i  (sram_rdata),
      .st_be_lo_o   (be_lo_s),
      .st_be_hi_o   (be_hi_s),
      .st_data_lo_o (data_lo_s),
      .st_data_hi_o (data_hi_s),
      .ld_data_o    (ld_data_s)
   );

   // State, captured request and first-beat load hold register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         memrw_q <= 3'b000;
         func3_q <= 3'b000;
         addr_q  <= {(SRAM_AW+2){1'b0}};
         wdata_q <= 32'h0000_0000;
         hold_q  <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         if (accept_s) begin
            memrw_q <= MemRW;
            func3_q <= func3;
            addr_q  <= addr[SRAM_AW+1:0];
            wdata_q <= wdata;
         end
         if (state_q == ST_ACC2) begin
            hold_q <= sram_rdata;
         end
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = accept_s ? ST_ACC1 : ST_IDLE;
         ST_ACC1: state_d = (!illegal_s && misaligned_s) ? ST_ACC2 : ST_RESP;
         ST_ACC2: state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // SRAM strobes per beat and the response, decoded from the current state.
   always_comb begin
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = {SRAM_AW{1'b0}};
      sram_be    = 4'h0;
      sram_wdata = 32'h0000_0000;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      rdata      = 32'h0000_0000;
      case (state_q)
         ST_ACC1: begin
            sram_en    = ~illegal_s;
            sram_we    = ~illegal_s & store_s;
            sram_addr  = word_addr_s;
            sram_be    = (!illegal_s && store_s) ? be_lo_s : 4'h0;
            sram_wdata = (!illegal_s && store_s) ? data_lo_s : 32'h0000_0000;
         end
         ST_ACC2: begin
            sram_en    = 1'b1;
            sram_we    = store_s;
            sram_addr  = word_addr_s + WORD_STEP;
            sram_be    = store_s ? be_hi_s : 4'h0;
            sram_wdata = store_s ? data_hi_s : 32'h0000_0000;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_err   = illegal_s;
            rdata      = (illegal_s || store_s) ? 32'h0000_0000 : ld_data_s;
         end
         default: begin
            resp_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed self-checking bench for lsu_mem_port with a behavioural word SRAM.
module tb_lsu_mem_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  MemRW;
   logic [2:0]  func3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        resp_err;
   logic        stall;
   logic        sram_en;
   logic        sram_we;
   logic [9:0]  sram_addr;
   logic [3:0]  sram_be;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   logic [31:0] mem [0:1023];
   logic [9:0]  wr_addr_log [0:31];
   logic [3:0]  wr_be_log   [0:31];
   logic [31:0] wr_data_log [0:31];
   int          wr_cnt = 0;
   int          en_cnt = 0;
   int          n_checks = 0;
   int          n_err = 0;

   lsu_mem_port #(.ADDR_W(32), .SRAM_AW(10)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .MemRW(MemRW), .func3(func3), .addr(addr), .wdata(wdata),
      .resp_valid(resp_valid), .rdata(rdata), .resp_err(resp_err), .stall(stall),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_be(sram_be),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   // SRAM model with one-cycle read latency, plus a write/strobe log.
   always @(posedge clk) begin
      if (sram_en) begin
         en_cnt <= en_cnt + 1;
         if (sram_we) begin
            for (int i = 0; i < 4; i++)
               if (sram_be[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
            wr_addr_log[wr_cnt[4:0]] <= sram_addr;
            wr_be_log[wr_cnt[4:0]]   <= sram_be;
            wr_data_log[wr_cnt[4:0]] <= sram_wdata;
            wr_cnt <= wr_cnt + 1;
         end
         sram_rdata <= mem[sram_addr];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_wr(input string tag, input int idx, input logic [9:0] a,
                           input logic [3:0] be, input logic [31:0] d);
      check_val({tag, "_addr"}, {22'h0, wr_addr_log[idx]}, {22'h0, a});
      check_val({tag, "_be"},   {28'h0, wr_be_log[idx]},   {28'h0, be});
      check_val({tag, "_data"}, wr_data_log[idx], d);
   endtask

   // Issue one request from IDLE and wait (bounded) for its response.
   task automatic access(input string tag, input logic [2:0] rw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                         input logic exp_err, input logic [31:0] exp_rd);
      int lat;
      bit seen;
      logic [31:0] rd;
      logic err;
      check_val({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1; MemRW = rw; func3 = f3; addr = a; wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_val({tag, "_stall"}, {31'h0, stall}, 32'h1);
      lat = 1; seen = 1'b0; rd = 32'h0; err = 1'b0;
      while (!seen && lat < 8) begin
         if (resp_valid) begin
            seen = 1'b1; rd = rdata; err = resp_err;
         end else begin
            @(posedge clk); #1; lat++;
         end
      end
      check_val({tag, "_lat"}, lat, exp_lat);
      check_val({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
      check_val({tag, "_rdata"}, rd, exp_rd);
      @(posedge clk); #1;
      check_val({tag, "_pulse"}, {31'h0, resp_valid}, 32'h0);
   endtask

   initial begin
      int base;
      int snap;
      int accepts;
      rst = 1'b1; req_valid = 1'b0; MemRW = 3'b000; func3 = 3'b000;
      addr = 32'h0; wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_ready", {31'h0, req_ready}, 32'h1);
      check_val("rst_stall", {31'h0, stall}, 32'h0);
      check_val("rst_resp", {31'h0, resp_valid}, 32'h0);
      check_val("rst_sram", {26'h0, sram_en, sram_we, sram_be}, 32'h0);
      check_val("rst_rdata", rdata, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // aligned word store then load
      base = wr_cnt;
      access("sw10", 3'b111, 3'b010, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0);
      check_val("sw10_nwr", wr_cnt - base, 1);
      check_wr("sw10_w", base, 10'd4, 4'b1111, 32'hDEADBEEF);
      access("lw10", 3'b010, 3'b000, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF);

      // extension checks on word 0 = 0x000080FF
      access("sw0", 3'b111, 3'b010, 32'h0, 32'h000080FF, 2, 1'b0, 32'h0);
      access("lb0",  3'b000, 3'b000, 32'h0, 32'h0, 2, 1'b0, 32'hFFFFFFFF);
      access("lbu0", 3'b110, 3'b000, 32'h0, 32'h0, 2, 1'b0, 32'h000000FF);
      access("lh0",  3'b001, 3'b000, 32'h0, 32'h0, 2, 1'b0, 32'hFFFF80FF);
      access("lhu0", 3'b101, 3'b000, 32'h0, 32'h0, 2, 1'b0, 32'h000080FF);
      access("lb1",  3'b000, 3'b000, 32'h1, 32'h0, 2, 1'b0, 32'hFFFFFF80);
      access("lbu1", 3'b110, 3'b000, 32'h1, 32'h0, 2, 1'b0, 32'h00000080);

      // misaligned word store/load and misaligned half
      base = wr_cnt;
      access("sw6", 3'b111, 3'b010, 32'h6, 32'h11223344, 3, 1'b0, 32'h0);
      check_val("sw6_nwr", wr_cnt - base, 2);
      check_wr("sw6_w0", base,     10'd1, 4'b1100, 32'h33440000);
      check_wr("sw6_w1", base + 1, 10'd2, 4'b0011, 32'h00001122);
      access("lw6", 3'b010, 3'b000, 32'h6, 32'h0, 3, 1'b0, 32'h11223344);
      access("lh7", 3'b001, 3'b000, 32'h7, 32'h0, 3, 1'b0, 32'h00002233);

      // byte store into lane 3 of word 4
      base = wr_cnt;
      access("sb13", 3'b111, 3'b000, 32'h13, 32'h000000AB, 2, 1'b0, 32'h0);
      check_wr("sb13_w", base, 10'd4, 4'b1000, 32'hAB000000);
      access("lw10b", 3'b010, 3'b000, 32'h10, 32'h0, 2, 1'b0, 32'hABADBEEF);

      // illegal codes: no SRAM activity
      snap = en_cnt;
      access("ill011", 3'b011, 3'b000, 32'h10, 32'h0, 2, 1'b1, 32'h0);
      access("ill100", 3'b100, 3'b000, 32'h10, 32'h0, 2, 1'b1, 32'h0);
      access("illsf3", 3'b111, 3'b011, 32'h10, 32'h55555555, 2, 1'b1, 32'h0);
      check_val("ill_no_en", en_cnt - snap, 0);

      // top-word wrap of the second beat
      base = wr_cnt;
      access("swtop", 3'b111, 3'b010, 32'hFFE, 32'hA1B2C3D4, 3, 1'b0, 32'h0);
      check_wr("swtop_w0", base,     10'd1023, 4'b1100, 32'hC3D40000);
      check_wr("swtop_w1", base + 1, 10'd0,    4'b0011, 32'h0000A1B2);
      access("lwtop", 3'b010, 3'b000, 32'hFFE, 32'h0, 3, 1'b0, 32'hA1B2C3D4);
      access("lw0wrap", 3'b010, 3'b000, 32'h0, 32'h0, 2, 1'b0, 32'h0000A1B2);

      // reset during ACC2 of a misaligned load
      req_valid = 1'b1; MemRW = 3'b010; func3 = 3'b000; addr = 32'h6;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_val("rma_acc1_en", {31'h0, sram_en}, 32'h1);
      @(posedge clk); #1;
      check_val("rma_acc2_addr", {22'h0, sram_addr}, 32'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      snap = en_cnt;
      check_val("rma_ready", {31'h0, req_ready}, 32'h1);
      check_val("rma_en", {31'h0, sram_en}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         check_val("rma_noresp", {31'h0, resp_valid}, 32'h0);
         @(posedge clk); #1;
      end
      check_val("rma_no_strobe", en_cnt - snap, 0);
      access("rma_lw", 3'b010, 3'b000, 32'h10, 32'h0, 2, 1'b0, 32'hABADBEEF);

      // back-to-back aligned loads with req_valid held high
      accepts = 0;
      req_valid = 1'b1; MemRW = 3'b010; func3 = 3'b000; addr = 32'h10;
      for (int i = 0; i < 9; i++) begin
         if (req_ready) accepts++;
         check_val("b2b_ready", {31'h0, req_ready}, {31'h0, (i % 3 == 0)});
         check_val("b2b_stall", {31'h0, stall}, {31'h0, (i % 3 != 0)});
         check_val("b2b_resp", {31'h0, resp_valid}, {31'h0, (i % 3 == 2)});
         if (i % 3 == 2) check_val("b2b_rdata", rdata, 32'hABADBEEF);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      check_val("b2b_accepts", accepts, 3);
      @(posedge clk); #1;
      check_val("b2b_idle", {31'h0, req_ready}, 32'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width.
REQ-002 Parameter: SRAM_AW, default 10, word-address width of the attached data SRAM (4 KiB).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 MemRW  input  3  access code from the control decoder: 000 LB, 001 LH, 010 LW, 101 LHU, 110 LBU, 111 store; 011/100 illegal.
REQ-008 func3  input  3  store width when MemRW=111: 000 SB, 001 SH, 010 SW; otherwise ignored.
REQ-009 addr  input  ADDR_W  byte address, the ALU result.
REQ-010 wdata  input  32  store data, taken from rs2.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  extended load result, valid only with resp_valid.
REQ-013 resp_err  output  1  illegal code flag, valid only with resp_valid.
REQ-014 stall  output  1  pipeline hold; equals NOT req_ready.
REQ-015 sram_en, sram_we  output  1 each  SRAM access strobe and write qualifier.
REQ-016 sram_addr  output  SRAM_AW  word address, taken from addr[SRAM_AW+1:2] plus the beat offset.
REQ-017 sram_be  output  4  byte-lane write enables; sram_wdata  output  32; sram_rdata  input  32, valid one cycle after the read strobe.

Function
REQ-018 FSM states: IDLE, ACC1, ACC2, RESP. req_ready=1 only in IDLE.
REQ-019 IDLE: on req_valid&&req_ready, register MemRW, func3, addr and wdata, then go to ACC1. Inputs are ignored in all other states.
REQ-020 Misaligned: set when the access crosses a 4-byte boundary, i.e. half with addr[1:0]=11 or word with addr[1:0]!=00.
REQ-021 ACC1: sram_en=1 at the base word. A store drives the low-beat lanes and data. Next state is ACC2 if misaligned, otherwise RESP.
REQ-022 ACC2: sram_en=1 at base word+1; a store drives the high-beat lanes. A load captures sram_rdata from ACC1 into a hold register. Next state is RESP.
REQ-023 RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Load rdata is taken from sram_rdata, combined with the hold register when misaligned.
- Bytes are taken little-endian starting at addr[1:0].
- LB/LH sign-extend; LBU/LHU zero-extend.
REQ-024 Latency, with acceptance in cycle T:
- aligned access: resp_valid in T+2;
- misaligned access: resp_valid in T+3;
- throughput is one request per 3 cycles (aligned) or 4 cycles (misaligned).
REQ-025 Illegal code (MemRW 011/100, or store with func3 outside 000-010): no SRAM access; ACC1 goes directly to RESP with resp_err=1 and rdata=0.
REQ-026 Word address wraps modulo 2^SRAM_AW; a misaligned access at the top word wraps its second beat to word 0.
REQ-027 Outside ACC1/ACC2: sram_en=0, sram_we=0, sram_be=0.

Reset
REQ-028 rst takes priority over all other activity. On the next edge: state=IDLE, and resp_valid, resp_err, rdata and all sram_* outputs are 0; registered request and hold register are cleared.
REQ-029 rst during ACC1/ACC2/RESP aborts the access: no further SRAM strobes and no resp_valid pulse. A partially written misaligned store is left as written.

Structure
REQ-030 A shared package holds the MemRW code constants, the FSM state encoding and the func3 width constants, shared with the control decoder.
REQ-031 One combinational sub-module, lsu_lane_fmt, produces store lane enables/data per beat and load extraction/extension.

Verification
REQ-032 Aligned word store then load: store at addr=0x10, wdata=0xDEADBEEF, then LW at 0x10 -> SRAM word 4 written with be=1111; rdata=0xDEADBEEF; each resp_valid two cycles after acceptance.
REQ-033 Sign versus zero extension: SRAM word 0=0x000080FF. LB at 0x0 -> 0xFFFFFFFF; LBU at 0x0 -> 0x000000FF; LH at 0x0 -> 0xFFFF80FF; LHU at 0x0 -> 0x000080FF.
REQ-034 Misaligned word: SW 0x11223344 at addr 0x6 -> word1 be=1100, word2 be=0011; LW at 0x6 returns 0x11223344 with resp_valid at T+3.
REQ-035 Illegal code: MemRW=011 -> no sram_en; resp_valid at T+2 with resp_err=1 and rdata=0.
REQ-036 Reset mid-access: assert rst in ACC2 of a misaligned LW -> no resp_valid; req_ready=1 the cycle after rst deasserts; next aligned LW completes normally.
REQ-037 Back-to-back: hold req_valid high over three aligned loads -> exactly three accepts, spaced 3 cycles apart; stall high during each ACC1 and RESP.
